// File: rtl/serv_rf_octal_pkg.sv
// Shared definitions for the serial register-file bridge.
//   rd_state_e    : read FSM state encoding
//   BYTES_PER_REG : bytes per register for the default 32-bit build
//   byte_addr()   : forms a bank byte address {reg index, byte select}
package serv_rf_octal_pkg;

  typedef enum logic [1:0] {StIdle, StFetch1, StFetch2, StStream} rd_state_e;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned BYTES_PER_REG = XLEN_DEF / 8;

  // Callers cast the result down to their bank address width.
  function automatic logic [15:0] byte_addr(logic [7:0] idx, logic [7:0] byte_sel,
                                            int unsigned byte_w);
    return (16'(idx) << byte_w) | 16'(byte_sel);
  endfunction

endpackage

// File: rtl/serv_rf_octal_if_if.sv
// Bus bundle between the serial core ports, the bridge and the byte-wide bank.
//   slave  : bridge view (core read/write requests and bank read data in; stream and bank
//            strobes out)
//   master : environment view (core side plus bank model)
interface serv_rf_octal_if_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
);
  localparam int unsigned RAM_AW = REG_AW + $clog2(XLEN / 8);

  logic              i_rreq;
  logic [REG_AW-1:0] i_rs1;
  logic [REG_AW-1:0] i_rs2;
  logic              o_rvalid;
  logic              o_rdata1;
  logic              o_rdata2;
  logic              o_busy;
  logic              i_wen;
  logic [REG_AW-1:0] i_rd;
  logic              i_wdata;
  logic [RAM_AW-1:0] o_raddr;
  logic [7:0]        i_rdata;
  logic [RAM_AW-1:0] o_waddr;
  logic [7:0]        o_wdata;
  logic              o_wen;

  modport slave (
    input  i_rreq, i_rs1, i_rs2, i_wen, i_rd, i_wdata, i_rdata,
    output o_rvalid, o_rdata1, o_rdata2, o_busy, o_raddr, o_waddr, o_wdata, o_wen
  );

  modport master (
    output i_rreq, i_rs1, i_rs2, i_wen, i_rd, i_wdata, i_rdata,
    input  o_rvalid, o_rdata1, o_rdata2, o_busy, o_raddr, o_waddr, o_wdata, o_wen
  );

endinterface

// File: rtl/serv_rf_octal_shift.sv
// 8-bit parallel-load shift register, LSB out. Load wins over shift.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i/data_i : parallel load of a bank byte
//   shift_i       : shift right one bit, zero fill
//   bit_o         : current LSB
module serv_rf_octal_shift (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic [7:0] data_i,
  output logic       bit_o
);

  logic [7:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {1'b0, sr_q[7:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign bit_o = sr_q[0];

endmodule

// File: rtl/serv_rf_octal_if.sv
// Bridge from bit-serial register-file ports to a byte-wide bank (registered read data, one
// cycle after o_raddr). Reads stream rs1/rs2 LSB-first; serial rd writes are packed into bytes.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus (slave)    : rreq/rs1/rs2 -> rvalid/rdata1/rdata2/busy stream; wen/rd/wdata serial
//                    write; raddr/rdata bank read port; waddr/wdata/wen bank write port
// Build option: SERV_RF_X0_ZERO_EN makes index 0 read as zero and blocks bank writes to it.
module serv_rf_octal_if
  import serv_rf_octal_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic               i_clk,
  input logic               i_rst_n,
  serv_rf_octal_if_if.slave bus
);

  localparam int unsigned BytesPerReg = XLEN / 8;
  localparam int unsigned ByteAw      = $clog2(BytesPerReg);
  localparam int unsigned CntW        = $clog2(XLEN);
  localparam int unsigned RamAw       = REG_AW + ByteAw;
  localparam logic [ByteAw-1:0] LastByte = ByteAw'(BytesPerReg - 1);
  localparam logic [CntW-1:0]   LastBit  = CntW'(XLEN - 1);

  // ---------------- read side ----------------
  rd_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [7:0]        pf1_q, pf1_d;  // rs1 next byte, arrives a cycle before it can be loaded

  logic [2:0]        bit_idx;
  logic [ByteAw-1:0] byte_idx, next_byte;
  logic              last_byte;
  logic [RamAw-1:0]  raddr;
  logic              ld1, ld2, shift_en, sh1_bit, sh2_bit, rd1_zero, rd2_zero;
  logic [7:0]        ld1_data;

  assign bit_idx   = cnt_q[2:0];
  assign byte_idx  = cnt_q[CntW-1:3];
  assign next_byte = byte_idx + ByteAw'(1);
  assign last_byte = (byte_idx == LastByte);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.i_rreq) state_d = StFetch1;
      StFetch1: state_d = StFetch2;
      StFetch2: state_d = StStream;
      StStream: if (cnt_q == LastBit) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    pf1_d = pf1_q;
    if (state_q == StIdle && bus.i_rreq) begin
      rs1_d = bus.i_rs1;
      rs2_d = bus.i_rs2;
    end
    if (state_q == StStream) begin
      cnt_d = (cnt_q == LastBit) ? '0 : cnt_q + CntW'(1);
      if (bit_idx == 3'd6 && !last_byte) pf1_d = bus.i_rdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      pf1_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      pf1_q <= pf1_d;
    end
  end

  // Address issue and shift-register loads. Prefetch for byte b+1: rs1 at bit 5, rs2 at bit 6,
  // both land in the shift registers at the bit 7 -> 0 boundary.
  always_comb begin
    raddr    = '0;
    ld1      = 1'b0;
    ld2      = 1'b0;
    ld1_data = pf1_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_rreq) raddr = RamAw'(byte_addr(8'(bus.i_rs1), 8'd0, ByteAw));
      end
      StFetch1: begin
        raddr    = RamAw'(byte_addr(8'(rs2_q), 8'd0, ByteAw));
        ld1      = 1'b1;
        ld1_data = bus.i_rdata;
      end
      StFetch2: ld2 = 1'b1;
      StStream: begin
        if (!last_byte) begin
          if (bit_idx == 3'd5) raddr = RamAw'(byte_addr(8'(rs1_q), 8'(next_byte), ByteAw));
          if (bit_idx == 3'd6) raddr = RamAw'(byte_addr(8'(rs2_q), 8'(next_byte), ByteAw));
          if (bit_idx == 3'd7) begin
            ld1 = 1'b1;
            ld2 = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign shift_en = (state_q == StStream);

`ifdef SERV_RF_X0_ZERO_EN
  assign rd1_zero = (rs1_q == '0);
  assign rd2_zero = (rs2_q == '0);
`else
  assign rd1_zero = 1'b0;
  assign rd2_zero = 1'b0;
`endif

  serv_rf_octal_shift u_sh1 (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .load_i (ld1),
    .shift_i(shift_en),
    .data_i (ld1_data),
    .bit_o  (sh1_bit)
  );

  serv_rf_octal_shift u_sh2 (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .load_i (ld2),
    .shift_i(shift_en),
    .data_i (bus.i_rdata),
    .bit_o  (sh2_bit)
  );

  assign bus.o_raddr  = raddr;
  assign bus.o_busy   = (state_q != StIdle);
  assign bus.o_rvalid = shift_en;
  assign bus.o_rdata1 = shift_en & sh1_bit & ~rd1_zero;
  assign bus.o_rdata2 = shift_en & sh2_bit & ~rd2_zero;

  // ---------------- write packer ----------------
  logic [2:0]        wbit_q, wbit_d;
  logic [ByteAw-1:0] wbyte_q, wbyte_d;
  logic [7:0]        pack_q, pack_d, wdata_q, wdata_d;
  logic [RamAw-1:0]  waddr_q, waddr_d;
  logic              wen_q, wen_d, wr_allow;

`ifdef SERV_RF_X0_ZERO_EN
  assign wr_allow = (bus.i_rd != '0);
`else
  assign wr_allow = 1'b1;
`endif

  always_comb begin
    wbit_d  = wbit_q;
    wbyte_d = wbyte_q;
    pack_d  = pack_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    wen_d   = 1'b0;
    if (bus.i_wen) begin
      pack_d = {bus.i_wdata, pack_q[7:1]};
      wbit_d = wbit_q + 3'd1;
      if (wbit_q == 3'd7) begin
        wen_d   = wr_allow;
        wdata_d = pack_d;
        waddr_d = RamAw'(byte_addr(8'(bus.i_rd), 8'(wbyte_q), ByteAw));
        wbyte_d = (wbyte_q == LastByte) ? '0 : wbyte_q + ByteAw'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wbit_q  <= '0;
      wbyte_q <= '0;
      pack_q  <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      wbit_q  <= wbit_d;
      wbyte_q <= wbyte_d;
      pack_q  <= pack_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      wen_q   <= wen_d;
    end
  end

  assign bus.o_wen   = wen_q;
  assign bus.o_wdata = wdata_q;
  assign bus.o_waddr = waddr_q;

endmodule

// File: tb/tb_serv_rf_octal_if.sv
module tb_serv_rf_octal_if;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

`ifdef SERV_RF_X0_ZERO_EN
  localparam bit X0_ZERO = 1'b1;
`else
  localparam bit X0_ZERO = 1'b0;
`endif
  localparam logic [31:0] X0_RD   = X0_ZERO ? 32'h0 : 32'hFFFF_FFFF;
  localparam int          X0_WENS = X0_ZERO ? 0 : 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   wen_seen = 0;

  always #5 clk = ~clk;

  serv_rf_octal_if_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

  serv_rf_octal_if #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // Bank model: registered read, old data on same-cycle read/write.
  logic [7:0] bank [128];
  always @(posedge clk) begin
    bus.i_rdata <= bank[bus.o_raddr];
    if (bus.o_wen) bank[bus.o_waddr] <= bus.o_wdata;
  end

  logic [1:0]  rq[$];  // {rdata1, rdata2} per stream bit
  logic [14:0] wq[$];  // {waddr, wdata} per bank write

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [1:0]  re;
    logic [14:0] we;
    if (bus.o_rvalid === 1'b1) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got rvalid=1 expected no stream bit");
      end else begin
        re = rq.pop_front();
        check("rdata1", 32'(bus.o_rdata1), 32'(re[1]));
        check("rdata2", 32'(bus.o_rdata2), 32'(re[0]));
      end
    end
    if (bus.o_wen === 1'b1) begin
      wen_seen++;
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got o_wen addr=%h expected none", bus.o_waddr);
      end else begin
        we = wq.pop_front();
        check("waddr", 32'(bus.o_waddr), 32'(we[14:8]));
        check("wdata", 32'(bus.o_wdata), 32'(we[7:0]));
      end
    end
  end

  function automatic bit wr_expected(input logic [4:0] rd);
    return !(X0_ZERO && rd == 5'd0);
  endfunction

  task automatic preload(input int r, input logic [31:0] v);
    for (int b = 0; b < 4; b++) bank[r*4+b] <= v[8*b +: 8];
  endtask

  task automatic start_read(input logic [4:0] r1, r2, input logic [31:0] e1, e2);
    @(negedge clk);
    bus.i_rreq = 1'b1;
    bus.i_rs1  = r1;
    bus.i_rs2  = r2;
    for (int i = 0; i < 32; i++) rq.push_back({e1[i], e2[i]});
    @(negedge clk);
    bus.i_rreq = 1'b0;
  endtask

  task automatic wait_rd_done(input string name);
    int n = 0;
    while ((bus.o_busy !== 1'b0 || rq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(rq.size()), 32'd0);
    rq.delete();
  endtask

  task automatic write_word(input logic [4:0] rd, input logic [31:0] d, input bit gaps);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bus.i_wen   = 1'b1;
      bus.i_rd    = rd;
      bus.i_wdata = d[i];
      if (i % 8 == 7 && wr_expected(rd)) wq.push_back({rd, 2'(i / 8), d[i-7 +: 8]});
      if (gaps) begin
        @(negedge clk);
        bus.i_wen = 1'b0;
      end
    end
    @(negedge clk);
    bus.i_wen = 1'b0;
    repeat (2) @(negedge clk);
    check("wq_drain", 32'(wq.size()), 32'd0);
    wq.delete();
  endtask

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
  } rd_vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        gaps;
  } wr_vec_t;

  rd_vec_t rtab[6];
  wr_vec_t wtab[3];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int w0;
    wtab[0] = '{rd: 5'd5,  data: 32'hA5A5_5A5A, gaps: 1'b0};
    wtab[1] = '{rd: 5'd12, data: 32'hA5A5_5A5A, gaps: 1'b1};
    wtab[2] = '{rd: 5'd9,  data: 32'h0BAD_F00D, gaps: 1'b0};
    rtab[0] = '{rs1: 5'd3, rs2: 5'd7,  e1: 32'hDEAD_BEEF, e2: 32'h1234_5678};
    rtab[1] = '{rs1: 5'd7, rs2: 5'd3,  e1: 32'h1234_5678, e2: 32'hDEAD_BEEF};
    rtab[2] = '{rs1: 5'd5, rs2: 5'd12, e1: 32'hA5A5_5A5A, e2: 32'hA5A5_5A5A};
    rtab[3] = '{rs1: 5'd9, rs2: 5'd3,  e1: 32'h0BAD_F00D, e2: 32'hDEAD_BEEF};
    rtab[4] = '{rs1: 5'd0, rs2: 5'd7,  e1: X0_RD,         e2: 32'h1234_5678};
    rtab[5] = '{rs1: 5'd3, rs2: 5'd3,  e1: 32'hDEAD_BEEF, e2: 32'hDEAD_BEEF};

    bus.i_rreq = 1'b0; bus.i_rs1 = '0; bus.i_rs2 = '0;
    bus.i_wen = 1'b0; bus.i_rd = '0; bus.i_wdata = 1'b0;
    for (int i = 0; i < 128; i++) bank[i] <= 8'h00;
    preload(0, 32'hFFFF_FFFF);
    preload(3, 32'hDEAD_BEEF);
    preload(7, 32'h1234_5678);

    repeat (3) @(negedge clk);
    check("rst_rvalid", 32'(bus.o_rvalid), 32'd0);
    check("rst_busy",   32'(bus.o_busy),   32'd0);
    check("rst_wen",    32'(bus.o_wen),    32'd0);
    check("rst_rdata1", 32'(bus.o_rdata1), 32'd0);
    check("rst_rdata2", 32'(bus.o_rdata2), 32'd0);
    check("rst_raddr",  32'(bus.o_raddr),  32'd0);
    check("rst_waddr",  32'(bus.o_waddr),  32'd0);
    check("rst_wdata",  32'(bus.o_wdata),  32'd0);
    rst_n = 1'b1;

    foreach (wtab[i]) write_word(wtab[i].rd, wtab[i].data, wtab[i].gaps);

    foreach (rtab[i]) begin
      start_read(rtab[i].rs1, rtab[i].rs2, rtab[i].e1, rtab[i].e2);
      check("busy_after_accept", 32'(bus.o_busy), 32'd1);
      wait_rd_done("rd_drain");
    end

    // rreq while busy is ignored; a held rreq is taken the cycle busy falls.
    start_read(5'd3, 5'd7, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (10) @(negedge clk);
    bus.i_rreq = 1'b1; bus.i_rs1 = 5'd10; bus.i_rs2 = 5'd11;
    @(negedge clk);
    bus.i_rreq = 1'b0;
    repeat (5) @(negedge clk);
    bus.i_rreq = 1'b1; bus.i_rs1 = 5'd5; bus.i_rs2 = 5'd9;
    n = 0;
    while (bus.o_busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_fall", 32'(bus.o_busy), 32'd0);
    check("first_stream_done", 32'(rq.size()), 32'd0);
    for (int i = 0; i < 32; i++) rq.push_back({wtab[0].data[i], wtab[2].data[i]});
    @(negedge clk);
    bus.i_rreq = 1'b0;
    check("b2b_busy", 32'(bus.o_busy), 32'd1);
    check("b2b_lat1", 32'(bus.o_rvalid), 32'd0);
    @(negedge clk);
    check("b2b_lat2", 32'(bus.o_rvalid), 32'd0);
    @(negedge clk);
    check("b2b_lat3", 32'(bus.o_rvalid), 32'd1);
    wait_rd_done("b2b_drain");

    // Reset while stream bit 13 is on the outputs.
    start_read(5'd7, 5'd3, 32'h1234_5678, 32'hDEAD_BEEF);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_rvalid", 32'(bus.o_rvalid), 32'd0);
    check("mid_rst_busy",   32'(bus.o_busy),   32'd0);
    check("mid_rst_rdata1", 32'(bus.o_rdata1), 32'd0);
    check("mid_rst_rdata2", 32'(bus.o_rdata2), 32'd0);
    check("mid_rst_bits_left", 32'(rq.size()), 32'd18);
    rq.delete();

    // Reset on write bit 4: partial byte must vanish and counters restart.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.i_wen = 1'b1; bus.i_rd = 5'd6; bus.i_wdata = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_wen = 1'b0;
    check("wr_rst_wen", 32'(bus.o_wen), 32'd0);
    w0 = wen_seen;
    write_word(5'd9, 32'h3C2D_1E0F, 1'b0);
    check("wr_rst_wen_count", 32'(wen_seen - w0), 32'd4);

    // Index 0 write.
    w0 = wen_seen;
    write_word(5'd0, 32'h1357_9BDF, 1'b0);
    check("x0_wen_count", 32'(wen_seen - w0), 32'(X0_WENS));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
